vregfile_vector_mp: RTL and testbench
=====================================

VREGFILE_VECTOR_MP -- requirements
Module: vregfile_vector_mp

Interface
REQ-001 Parameter NUMBANKS, default 1: number of independent register banks (lanes).
REQ-002 Parameter LOG2NUMBANKS, default 0: log2 of NUMBANKS.
REQ-003 Parameter WIDTH, default 32: data bits per bank entry.
REQ-004 Parameter NUMREGS, default 32: total registers; NUMREGSPERBANK = NUMREGS/NUMBANKS.
REQ-005 Parameter LOG2NUMREGS, default 5: log2 of NUMREGS; LOG2NUMREGSPERBANK = LOG2NUMREGS-LOG2NUMBANKS.
REQ-006 Parameter NUMRDPORTS, default 2: read ports per bank, range 1..4.
REQ-007 Derived BEW = (WIDTH>=8) ? WIDTH/8 : 1: byte-enable bits per bank.
REQ-008 clk  input  1  single clock; all state on rising edge.
REQ-009 resetn  input  1  reset, asynchronous and active-low.
REQ-010 rd_reg  input  NUMRDPORTS*NUMBANKS*LOG2NUMREGSPERBANK  read addresses; port p, bank k at slice (p*NUMBANKS+k).
REQ-011 rd_en  input  NUMRDPORTS*NUMBANKS  read enables, same ordering.
REQ-012 rd_data  output  NUMRDPORTS*NUMBANKS*WIDTH  read data, same ordering.
REQ-013 c_reg  input  NUMBANKS*LOG2NUMREGSPERBANK  write address per bank.
REQ-014 c_writedatain  input  NUMBANKS*WIDTH  write data per bank.
REQ-015 c_byteen  input  NUMBANKS*BEW  byte enables per bank.
REQ-016 c_we  input  NUMBANKS  write enable per bank.
REQ-017 clear_req  input  1  one-cycle pulse requesting zeroing of all registers.
REQ-018 busy  output  1  high while clear sequence runs.

Function
REQ-019 Read latency SHALL be 1 cycle: rd_en high at edge N loads rd_data at edge N with contents of rd_reg; visible after edge N.
REQ-020 With rd_en low, the port's rd_data SHALL hold its previous value.
REQ-021 Write with c_we[k]=1 SHALL update bank k entry c_reg at the edge, only bytes with c_byteen set; for WIDTH<8 the single enable bit gates the whole word.
REQ-022 Same-cycle write and read of the same bank/address SHALL return new data: enabled bytes from c_writedatain, other bytes from stored value (write-first bypass).
REQ-023 All read ports of a bank SHALL be independent; any number may address the same register in one cycle.
REQ-024 Banks SHALL be fully independent; no cross-bank addressing.
REQ-025 Clear FSM states: CLEAR, READY.
REQ-026 CLEAR: counter clr_idx steps 0..NUMREGSPERBANK-1, one per cycle, zeroing entry clr_idx in every bank; after last index -> READY; duration exactly NUMREGSPERBANK cycles.
REQ-027 READY -> CLEAR on clear_req=1; clr_idx restarts at 0.
REQ-028 clear_req while in CLEAR SHALL restart clr_idx at 0.
REQ-029 busy SHALL be 1 exactly while state is CLEAR.
REQ-030 During CLEAR, c_we SHALL be ignored (clear wins over same-cycle write) and enabled reads SHALL load 0.
REQ-031 Write in the cycle clear_req is sampled in READY SHALL be discarded.

Reset
REQ-032 resetn low SHALL asynchronously force state CLEAR, clr_idx 0, busy 1, all rd_data 0.
REQ-033 After resetn deasserts, full clear SHALL complete before busy drops; register array needs no reset of its own.
REQ-034 resetn asserted mid-clear SHALL restart the sequence from index 0.

Verification
REQ-035 Reset release, defaults -> busy=1 for 32 cycles, then 0; read of every register returns 0x00000000.
REQ-036 Write reg 5 = 0xDEADBEEF byteen 4'b1111, next cycle read reg 5 on ports 0 and 1 -> both 0xDEADBEEF after 1 cycle.
REQ-037 Reg 5 = 0xDEADBEEF; same cycle write 0x11223344 byteen 4'b0101 and read reg 5 -> 0xDE22BE44.
REQ-038 NUMBANKS=4, NUMREGS=32: bank 2 writes reg 3 = 0xA5A5A5A5 while other banks idle -> only bank 2 reg 3 changes; others read 0.
REQ-039 READY, write reg 7 = 0x1 with clear_req same cycle -> write discarded, busy=1 for 32 cycles, reg 7 reads 0.
REQ-040 clear_req at clr_idx=10, rd_en held low across -> busy stays high 32 cycles after second pulse; rd_data unchanged throughout.

Source files
------------

// File: rtl/vregfile_vector_mp_if.sv
// Bus bundle for vregfile_vector_mp: read ports, per-bank write port,
// clear request and busy status.
//   rd_reg/rd_en/rd_data : read address/enable/data, lane (port*NUMBANKS+bank)
//   c_reg/c_writedatain/c_byteen/c_we : write address/data/byte-enable/enable per bank
//   clear_req : one-cycle pulse starting a clear of all registers
//   busy      : high while the clear sequence runs
// master drives requests, slave is the register file.
interface vregfile_vector_mp_if #(
  parameter int NUMBANKS     = 1,
  parameter int LOG2NUMBANKS = 0,
  parameter int WIDTH        = 32,
  parameter int NUMREGS      = 32,
  parameter int LOG2NUMREGS  = 5,
  parameter int NUMRDPORTS   = 2
);
  localparam int LOG2NUMREGSPERBANK = LOG2NUMREGS - LOG2NUMBANKS;
  localparam int BEW                = (WIDTH >= 8) ? WIDTH / 8 : 1;

  logic [NUMRDPORTS*NUMBANKS*LOG2NUMREGSPERBANK-1:0] rd_reg;
  logic [NUMRDPORTS*NUMBANKS-1:0]                    rd_en;
  logic [NUMRDPORTS*NUMBANKS*WIDTH-1:0]              rd_data;
  logic [NUMBANKS*LOG2NUMREGSPERBANK-1:0]            c_reg;
  logic [NUMBANKS*WIDTH-1:0]                         c_writedatain;
  logic [NUMBANKS*BEW-1:0]                           c_byteen;
  logic [NUMBANKS-1:0]                               c_we;
  logic                                              clear_req;
  logic                                              busy;

  modport master (
    output rd_reg, rd_en, c_reg, c_writedatain, c_byteen, c_we, clear_req,
    input  rd_data, busy
  );

  modport slave (
    input  rd_reg, rd_en, c_reg, c_writedatain, c_byteen, c_we, clear_req,
    output rd_data, busy
  );
endinterface

// File: rtl/vregfile_vector_mp.sv
// Banked multi-read-port vector register file with byte-enabled writes,
// write-first bypass and a self-timed clear sequence.
//   clk    : clock, all state on rising edge
//   resetn : asynchronous active-low reset (restarts the clear sequence)
//   bus    : vregfile_vector_mp_if slave modport (reads, writes, clear, busy)
module vregfile_vector_mp #(
  parameter int NUMBANKS     = 1,
  parameter int LOG2NUMBANKS = 0,
  parameter int WIDTH        = 32,
  parameter int NUMREGS      = 32,
  parameter int LOG2NUMREGS  = 5,
  parameter int NUMRDPORTS   = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  vregfile_vector_mp_if.slave  bus
);
  localparam int NUMREGSPERBANK     = NUMREGS / NUMBANKS;
  localparam int LOG2NUMREGSPERBANK = LOG2NUMREGS - LOG2NUMBANKS;
  localparam int BEW                = (WIDTH >= 8) ? WIDTH / 8 : 1;
  localparam int NLANES             = NUMRDPORTS * NUMBANKS;
  localparam int L                  = LOG2NUMREGSPERBANK;
  localparam logic [L-1:0] LAST_IDX = L'(NUMREGSPERBANK - 1);

  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e         state_q, state_d;
  logic [L-1:0]   clr_idx_q, clr_idx_d;

  logic [WIDTH-1:0] mem_q     [NUMBANKS][NUMREGSPERBANK];
  logic [WIDTH-1:0] wr_merged [NUMBANKS];
  logic [NUMBANKS-1:0] wr_go;
  logic [WIDTH-1:0] rd_data_q [NLANES];
  logic [WIDTH-1:0] rd_data_d [NLANES];

  // Bytes beyond the last full byte (WIDTH not a multiple of 8) share the top enable.
  function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_w,
                                                   input logic [WIDTH-1:0] new_w,
                                                   input logic [BEW-1:0]   be);
    logic [WIDTH-1:0] r;
    int unsigned      bi;
    r = old_w;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      bi = i / 8;
      if (bi >= BEW) bi = BEW - 1;
      r[i] = be[bi] ? new_w[i] : old_w[i];
    end
    return r;
  endfunction

  // Clear sequencer; a clear_req in either state (re)starts from index 0.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      S_CLEAR: begin
        if (bus.clear_req) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == LAST_IDX) begin
          state_d   = S_READY;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      S_READY: begin
        if (bus.clear_req) begin
          state_d   = S_CLEAR;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = S_CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // A write commits only in READY with no clear being requested that cycle.
  always_comb begin
    for (int unsigned k = 0; k < NUMBANKS; k++) begin
      wr_go[k]     = (state_q == S_READY) && !bus.clear_req && bus.c_we[k];
      wr_merged[k] = merge_bytes(mem_q[k][bus.c_reg[k*L +: L]],
                                 bus.c_writedatain[k*WIDTH +: WIDTH],
                                 bus.c_byteen[k*BEW +: BEW]);
    end
  end

  // Storage array carries no reset; the clear sequence initialises it.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NUMBANKS; k++) begin
      if (state_q == S_CLEAR) begin
        mem_q[k][clr_idx_q] <= '0;
      end else if (wr_go[k]) begin
        mem_q[k][bus.c_reg[k*L +: L]] <= wr_merged[k];
      end
    end
  end

  // Read lanes: zero during clear, write-first bypass on address match, else array.
  always_comb begin
    for (int unsigned p = 0; p < NUMRDPORTS; p++) begin
      for (int unsigned k = 0; k < NUMBANKS; k++) begin
        rd_data_d[p*NUMBANKS+k] = rd_data_q[p*NUMBANKS+k];
        if (bus.rd_en[p*NUMBANKS+k]) begin
          if (state_q == S_CLEAR) begin
            rd_data_d[p*NUMBANKS+k] = '0;
          end else if (wr_go[k] &&
                       (bus.c_reg[k*L +: L] == bus.rd_reg[(p*NUMBANKS+k)*L +: L])) begin
            rd_data_d[p*NUMBANKS+k] = wr_merged[k];
          end else begin
            rd_data_d[p*NUMBANKS+k] = mem_q[k][bus.rd_reg[(p*NUMBANKS+k)*L +: L]];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NLANES; i++) rd_data_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NLANES; i++) rd_data_q[i] <= rd_data_d[i];
    end
  end

  for (genvar g = 0; g < NLANES; g++) begin : g_rd_out
    assign bus.rd_data[g*WIDTH +: WIDTH] = rd_data_q[g];
  end

  assign bus.busy = (state_q == S_CLEAR);
endmodule

// File: tb/tb_vregfile_vector_mp.sv
module tb_vregfile_vector_mp;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  vregfile_vector_mp_if bus_a ();
  vregfile_vector_mp_if #(.NUMBANKS(4), .LOG2NUMBANKS(2), .NUMREGS(32), .LOG2NUMREGS(5)) bus_b ();

  vregfile_vector_mp u_a (.clk(clk), .resetn(resetn), .bus(bus_a));
  vregfile_vector_mp #(.NUMBANKS(4), .LOG2NUMBANKS(2), .NUMREGS(32), .LOG2NUMREGS(5))
    u_b (.clk(clk), .resetn(resetn), .bus(bus_b));

  typedef struct { int unsigned lane; logic [31:0] data; } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];
  int errors = 0;
  int checks = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Which lanes were enabled at the last edge, i.e. which rd_data are fresh.
  logic [1:0] en_a_q;
  logic [7:0] en_b_q;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en_a_q <= '0;
      en_b_q <= '0;
    end else begin
      en_a_q <= bus_a.rd_en;
      en_b_q <= bus_b.rd_en;
    end
  end

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (resetn) begin
      for (int i = 0; i < 2; i++) begin
        if (en_a_q[i]) begin
          if (q_a.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_unexpected_read lane %0d: got %h expected none", i, bus_a.rd_data[i*32 +: 32]);
          end else begin
            e = q_a.pop_front();
            check32($sformatf("a_read_lane%0d", i), bus_a.rd_data[i*32 +: 32], e.data);
            if (e.lane != i) begin
              checks++; errors++;
              $display("FAIL a_lane_order: got lane %0d expected lane %0d", i, e.lane);
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (resetn) begin
      for (int i = 0; i < 8; i++) begin
        if (en_b_q[i]) begin
          if (q_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected_read lane %0d: got %h expected none", i, bus_b.rd_data[i*32 +: 32]);
          end else begin
            e = q_b.pop_front();
            check32($sformatf("b_read_lane%0d", i), bus_b.rd_data[i*32 +: 32], e.data);
            if (e.lane != i) begin
              checks++; errors++;
              $display("FAIL b_lane_order: got lane %0d expected lane %0d", i, e.lane);
            end
          end
        end
      end
    end
  end

  task automatic push_a(input int unsigned lane, input logic [31:0] d);
    q_a.push_back('{lane: lane, data: d});
  endtask
  task automatic push_b(input int unsigned lane, input logic [31:0] d);
    q_b.push_back('{lane: lane, data: d});
  endtask

  task automatic a_cycle(input logic [1:0] en, input logic [4:0] r0, input logic [4:0] r1,
                         input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                         input logic [3:0] be, input logic clr);
    @(negedge clk);
    bus_a.rd_en = en; bus_a.rd_reg = {r1, r0};
    bus_a.c_we = we; bus_a.c_reg = wreg; bus_a.c_writedatain = wdata; bus_a.c_byteen = be;
    bus_a.clear_req = clr;
    @(posedge clk); #1;
    bus_a.rd_en = '0; bus_a.c_we = '0; bus_a.clear_req = 1'b0;
  endtask

  task automatic b_cycle(input logic [7:0] en, input logic [2:0] raddr, input logic [3:0] we,
                         input logic [2:0] waddr, input logic [127:0] wdata,
                         input logic [15:0] be, input logic clr);
    @(negedge clk);
    bus_b.rd_en = en; bus_b.rd_reg = {8{raddr}};
    bus_b.c_we = we; bus_b.c_reg = {4{waddr}}; bus_b.c_writedatain = wdata; bus_b.c_byteen = be;
    bus_b.clear_req = clr;
    @(posedge clk); #1;
    bus_b.rd_en = '0; bus_b.c_we = '0; bus_b.clear_req = 1'b0;
  endtask

  // Counts edges spent in CLEAR (starting from 'start') until busy drops.
  task automatic wait_busy_a(input int start, input int expn, input string name,
                             input bit hold, input logic [31:0] hv);
    int n = start;
    check32({name, "_busy_start"}, {31'b0, bus_a.busy}, 32'd1);
    while (bus_a.busy && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (hold) begin
        check32({name, "_hold_lane0"}, bus_a.rd_data[31:0], hv);
        check32({name, "_hold_lane1"}, bus_a.rd_data[63:32], hv);
      end
    end
    check32({name, "_busy_cycles"}, n, expn);
  endtask

  initial begin
    resetn = 1'b0;
    bus_a.rd_en = '0; bus_a.rd_reg = '0; bus_a.c_we = '0; bus_a.c_reg = '0;
    bus_a.c_writedatain = '0; bus_a.c_byteen = '0; bus_a.clear_req = 1'b0;
    bus_b.rd_en = '0; bus_b.rd_reg = '0; bus_b.c_we = '0; bus_b.c_reg = '0;
    bus_b.c_writedatain = '0; bus_b.c_byteen = '0; bus_b.clear_req = 1'b0;

    // Reset state
    #22;
    check32("a_reset_busy", {31'b0, bus_a.busy}, 32'd1);
    check32("a_reset_rd0", bus_a.rd_data[31:0], 32'h0);
    check32("a_reset_rd1", bus_a.rd_data[63:32], 32'h0);
    check32("b_reset_busy", {31'b0, bus_b.busy}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    wait_busy_a(0, 32, "a_post_reset", 1'b0, 32'h0);
    check32("b_post_reset_ready", {31'b0, bus_b.busy}, 32'd0);

    // Every register reads zero after the clear
    for (int i = 0; i < 32; i++) begin
      push_a(0, 32'h0); push_a(1, 32'h0);
      a_cycle(2'b11, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
    end

    // Full write then read on both ports
    a_cycle(2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 4'b1111, 1'b0);
    push_a(0, 32'hDEADBEEF); push_a(1, 32'hDEADBEEF);
    a_cycle(2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0);

    // Partial write with same-cycle read: write-first bypass merges bytes
    push_a(0, 32'hDE22BE44); push_a(1, 32'hDE22BE44);
    a_cycle(2'b11, 5'd5, 5'd5, 1'b1, 5'd5, 32'h11223344, 4'b0101, 1'b0);
    push_a(0, 32'hDE22BE44); push_a(1, 32'h0);
    a_cycle(2'b11, 5'd5, 5'd6, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0);

    // No byte enables and no write enable leave storage untouched
    a_cycle(2'b00, 5'd0, 5'd0, 1'b1, 5'd6, 32'hFFFFFFFF, 4'b0000, 1'b0);
    a_cycle(2'b00, 5'd0, 5'd0, 1'b0, 5'd8, 32'hAAAAAAAA, 4'b1111, 1'b0);
    push_a(1, 32'h0);
    a_cycle(2'b10, 5'd0, 5'd6, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
    push_a(1, 32'h0);
    a_cycle(2'b10, 5'd0, 5'd8, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
    check32("a_hold_lane0", bus_a.rd_data[31:0], 32'hDE22BE44);

    // Clear request wins over same-cycle write; writes during CLEAR ignored, reads give 0
    push_a(0, 32'hDE22BE44);
    a_cycle(2'b01, 5'd5, 5'd0, 1'b1, 5'd7, 32'h00000001, 4'b1111, 1'b1);
    for (int j = 1; j <= 10; j++) begin
      if (j == 3) begin
        push_a(0, 32'h0);
        a_cycle(2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
      end else if (j == 6) begin
        a_cycle(2'b00, 5'd0, 5'd0, 1'b1, 5'd2, 32'h00000055, 4'b1111, 1'b0);
      end else begin
        a_cycle(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
      end
    end
    wait_busy_a(10, 32, "a_clear_req", 1'b0, 32'h0);
    push_a(0, 32'h0); push_a(1, 32'h0);
    a_cycle(2'b11, 5'd7, 5'd2, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
    push_a(0, 32'h0);
    a_cycle(2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0);

    // Clear restart at index 10 with reads disabled: rd_data holds
    a_cycle(2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 32'h12345678, 4'b1111, 1'b0);
    push_a(0, 32'h12345678); push_a(1, 32'h12345678);
    a_cycle(2'b11, 5'd9, 5'd9, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
    a_cycle(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1);
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      check32("a_restart_hold_lane0", bus_a.rd_data[31:0], 32'h12345678);
      check32("a_restart_hold_lane1", bus_a.rd_data[63:32], 32'h12345678);
    end
    a_cycle(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1);
    wait_busy_a(0, 32, "a_restart", 1'b1, 32'h12345678);

    // Four banks: only bank 2 reg 3 is written
    b_cycle(8'h00, 3'd0, 4'b0100, 3'd3,
            {32'h44444444, 32'hA5A5A5A5, 32'h22222222, 32'h11111111}, 16'hFFFF, 1'b0);
    for (int i = 0; i < 8; i++) push_b(i, ((i % 4) == 2) ? 32'hA5A5A5A5 : 32'h0);
    b_cycle(8'hFF, 3'd3, 4'b0000, 3'd0, 128'h0, 16'h0, 1'b0);

    // Bank 1 bypass with top byte only
    push_b(1, 32'hFF000000);
    b_cycle(8'h02, 3'd4, 4'b0010, 3'd4, {32'h0, 32'h0, 32'hFFFFFFFF, 32'h0}, 16'h0080, 1'b0);
    for (int i = 4; i < 8; i++) push_b(i, (i == 5) ? 32'hFF000000 : 32'h0);
    b_cycle(8'hF0, 3'd4, 4'b0000, 3'd0, 128'h0, 16'h0, 1'b0);

    // Four-bank clear lasts 8 cycles and wipes bank 2 reg 3
    b_cycle(8'h00, 3'd0, 4'b0000, 3'd0, 128'h0, 16'h0, 1'b1);
    begin
      int n = 0;
      check32("b_clear_busy_start", {31'b0, bus_b.busy}, 32'd1);
      while (bus_b.busy && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check32("b_clear_busy_cycles", n, 32'd8);
    end
    for (int i = 0; i < 8; i++) push_b(i, 32'h0);
    b_cycle(8'hFF, 3'd3, 4'b0000, 3'd0, 128'h0, 16'h0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check32("a_queue_drained", q_a.size(), 32'd0);
    check32("b_queue_drained", q_b.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
